// File: rtl/platformer_pkg.sv
// Shared constants for the platformer control path: key map and debounce timing.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package platformer_pkg;

    localparam int N_KEYS = 3;

    // Channel index of each button in the key vectors
    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_JUMP  = 2;

    // 10 ms of stability at the 25 MHz pixel clock
    localparam int DEBOUNCE_CYCLES_25MHZ = 250000;
    // Short window so benches reach accepted edges in a handful of cycles
    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CNT_W        = 18;

    // True when a counter of the given width can hold cycles-1 without wrapping
    function automatic bit cnt_fits(input int cycles, input int width);
        return (longint'(1) << width) > longint'(cycles);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button-side and game-side signals of the key conditioner, bundled.
// Latency: n/a (wiring only).
// Backpressure: none; all outputs are levels or single-cycle pulses.
interface key_conditioner_if
    import platformer_pkg::*;
#(
    parameter int N = N_KEYS
);
    logic [N-1:0] key_n;
    logic         frame_tick;
    logic [N-1:0] held;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] press_evt;

    // Producer of raw buttons and frame ticks (board / bench side)
    modport master (
        output key_n,
        output frame_tick,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  press_evt
    );

    // The conditioner itself
    modport slave (
        input  key_n,
        input  frame_tick,
        output held,
        output press_pulse,
        output release_pulse,
        output press_evt
    );

endinterface

// File: rtl/key_conditioner_debounce.sv
// One button: 2-FF sync, stability counter, held level, press/release pulses, sticky press event.
// Latency: raw edge to held/pulse is 2 + DEBOUNCE_CYCLES clocks; press_evt follows one clock later.
// Backpressure: none; press_evt holds a press until frame_tick acknowledges it.
module debounce_channel
    import platformer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25MHZ,
    parameter int CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic frame_tick,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_evt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt;

    assign pressed_s = ~sync2;

    // Two-flop synchroniser; resets to the released level so a held key is not seen as an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing cycles; any agreement restarts, the last one accepts the change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else if (pressed_s == held) begin
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt           <= '0;
            held          <= pressed_s;
            press_pulse   <= pressed_s;
            release_pulse <= ~pressed_s;
        end else begin
            cnt           <= cnt + CNT_ONE;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end
    end

    // Sticky press: a pulse coinciding with frame_tick wins, so that press lands in the next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_evt <= 1'b0;
        end else begin
            press_evt <= press_pulse | (press_evt & ~frame_tick);
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low buttons into clean levels, edge pulses and per-frame press events.
// Latency: 2 + DEBOUNCE_CYCLES clocks from a stable raw edge to held/pulse, identical on every key.
// Backpressure: none; press_evt is held until frame_tick, which is fanned out to every channel.
module key_conditioner
    import platformer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25MHZ,
    parameter int CNT_W           = DEBOUNCE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    key_conditioner_if.slave kif
);

    logic [N_KEYS-1:0] held_w;
    logic [N_KEYS-1:0] press_pulse_w;
    logic [N_KEYS-1:0] release_pulse_w;
    logic [N_KEYS-1:0] press_evt_w;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_n         (kif.key_n[gi]),
            .frame_tick    (kif.frame_tick),
            .held          (held_w[gi]),
            .press_pulse   (press_pulse_w[gi]),
            .release_pulse (release_pulse_w[gi]),
            .press_evt     (press_evt_w[gi])
        );
    end

    assign kif.held          = held_w;
    assign kif.press_pulse   = press_pulse_w;
    assign kif.release_pulse = release_pulse_w;
    assign kif.press_evt     = press_evt_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a 4-cycle debounce window.
// Stimulus pushes expected pulses and output snapshots keyed by cycle; a negedge monitor checks them.
// Any pulse not announced by the stimulus is reported.
module tb_key_conditioner;
    import platformer_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] pp;
        logic [2:0] rp;
    } pulse_t;

    typedef struct {
        int         cyc;
        logic [2:0] held;
        logic [2:0] pp;
        logic [2:0] rp;
        logic [2:0] evt;
    } lvl_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     cyc = 0;
    int     chk_cnt = 0;
    int     pass_cnt = 0;
    pulse_t pq[$];
    lvl_t   lq[$];
    pulse_t pe;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM),
        .CNT_W           (DEBOUNCE_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pulse(input int c, input logic [2:0] pp, input logic [2:0] rp);
        pulse_t e;
        e.cyc = c; e.pp = pp; e.rp = rp;
        pq.push_back(e);
    endtask

    task automatic push_lvl(input int c, input logic [2:0] h, input logic [2:0] pp,
                            input logic [2:0] rp, input logic [2:0] ev);
        lvl_t e;
        e.cyc = c; e.held = h; e.pp = pp; e.rp = rp; e.evt = ev;
        lq.push_back(e);
    endtask

    // One-cycle frame tick; the caller states the held value expected while it clears press_evt
    task automatic frame(input logic [2:0] h);
        push_lvl(cyc + 1, h, 3'b000, 3'b000, 3'b000);
        kif.frame_tick = 1'b1;
        step(1);
        kif.frame_tick = 1'b0;
    endtask

    // Monitor: every pulse must match the next announced pulse; snapshots are checked on their cycle
    always @(negedge clk) begin
        if ((kif.press_pulse | kif.release_pulse) != 3'b000) begin
            chk_cnt++;
            if (pq.size() == 0) begin
                $display("FAIL pulse_unexpected cyc=%0d got pp=%b rp=%b, required no pulse",
                         cyc, kif.press_pulse, kif.release_pulse);
            end else begin
                pe = pq.pop_front();
                if (pe.cyc == cyc && pe.pp == kif.press_pulse && pe.rp == kif.release_pulse)
                    pass_cnt++;
                else
                    $display("FAIL pulse got cyc=%0d pp=%b rp=%b, required cyc=%0d pp=%b rp=%b",
                             cyc, kif.press_pulse, kif.release_pulse, pe.cyc, pe.pp, pe.rp);
            end
        end
        for (int i = lq.size() - 1; i >= 0; i--) begin
            if (lq[i].cyc == cyc) begin
                chk_cnt++;
                if (kif.held == lq[i].held && kif.press_pulse == lq[i].pp &&
                    kif.release_pulse == lq[i].rp && kif.press_evt == lq[i].evt)
                    pass_cnt++;
                else
                    $display("FAIL level cyc=%0d got held=%b pp=%b rp=%b evt=%b, required held=%b pp=%b rp=%b evt=%b",
                             cyc, kif.held, kif.press_pulse, kif.release_pulse, kif.press_evt,
                             lq[i].held, lq[i].pp, lq[i].rp, lq[i].evt);
                lq.delete(i);
            end
        end
    end

    initial begin
        int t;
        int f;
        rst_n          = 1'b0;
        kif.key_n      = 3'b000;
        kif.frame_tick = 1'b0;

        // Reset with all keys down: everything quiet, then all three accepted together
        step(1);
        push_lvl(cyc + 1, 3'b000, 3'b000, 3'b000, 3'b000);
        push_lvl(cyc + 2, 3'b000, 3'b000, 3'b000, 3'b000);
        step(3);
        rst_n = 1'b1;
        t = cyc;
        push_lvl(t + 5, 3'b000, 3'b000, 3'b000, 3'b000);
        push_pulse(t + 6, 3'b111, 3'b000);
        push_lvl(t + 6, 3'b111, 3'b111, 3'b000, 3'b000);
        push_lvl(t + 7, 3'b111, 3'b000, 3'b000, 3'b111);
        step(8);
        frame(3'b111);
        kif.key_n = 3'b111;
        t = cyc;
        push_pulse(t + 6, 3'b000, 3'b111);
        push_lvl(t + 6, 3'b000, 3'b000, 3'b111, 3'b000);
        step(10);

        // Clean press then release on key 0; release leaves press_evt alone
        t = cyc;
        kif.key_n[0] = 1'b0;
        push_pulse(t + 6, 3'b001, 3'b000);
        push_lvl(t + 6, 3'b001, 3'b001, 3'b000, 3'b000);
        push_lvl(t + 7, 3'b001, 3'b000, 3'b000, 3'b001);
        step(20);
        kif.key_n[0] = 1'b1;
        push_lvl(t + 25, 3'b001, 3'b000, 3'b000, 3'b001);
        push_pulse(t + 26, 3'b000, 3'b001);
        push_lvl(t + 26, 3'b000, 3'b000, 3'b001, 3'b001);
        step(10);
        frame(3'b000);

        // Bounce on key 2: two runs of three stable cycles fall one short of acceptance
        t = cyc;
        push_lvl(t + 7, 3'b000, 3'b000, 3'b000, 3'b000);
        push_lvl(t + 10, 3'b000, 3'b000, 3'b000, 3'b000);
        kif.key_n[2] = 1'b0; step(3);
        kif.key_n[2] = 1'b1; step(1);
        kif.key_n[2] = 1'b0; step(3);
        kif.key_n[2] = 1'b1; step(1);
        kif.key_n[2] = 1'b0;
        f = cyc;
        push_lvl(f + 5, 3'b000, 3'b000, 3'b000, 3'b000);
        push_pulse(f + 6, 3'b100, 3'b000);
        push_lvl(f + 6, 3'b100, 3'b100, 3'b000, 3'b000);
        push_lvl(f + 7, 3'b100, 3'b000, 3'b000, 3'b100);
        step(10);
        kif.key_n[2] = 1'b1;
        t = cyc;
        push_pulse(t + 6, 3'b000, 3'b100);
        push_lvl(t + 6, 3'b000, 3'b000, 3'b100, 3'b100);
        step(10);
        frame(3'b000);

        // Frame tick in the same cycle as press_pulse[1]: the press survives into the next frame
        t = cyc;
        kif.key_n[1] = 1'b0;
        push_pulse(t + 6, 3'b010, 3'b000);
        push_lvl(t + 6, 3'b010, 3'b010, 3'b000, 3'b000);
        push_lvl(t + 7, 3'b010, 3'b000, 3'b000, 3'b010);
        step(6);
        kif.frame_tick = 1'b1;
        step(1);
        kif.frame_tick = 1'b0;
        step(3);
        frame(3'b010);
        kif.key_n[1] = 1'b1;
        t = cyc;
        push_pulse(t + 6, 3'b000, 3'b010);
        push_lvl(t + 6, 3'b000, 3'b000, 3'b010, 3'b000);
        step(10);

        // Two accepted presses on key 0 in one frame collapse to one event
        t = cyc;
        kif.key_n[0] = 1'b0;
        push_pulse(t + 6, 3'b001, 3'b000);
        step(8);
        kif.key_n[0] = 1'b1;
        push_pulse(t + 14, 3'b000, 3'b001);
        push_lvl(t + 15, 3'b000, 3'b000, 3'b000, 3'b001);
        step(8);
        kif.key_n[0] = 1'b0;
        push_pulse(t + 22, 3'b001, 3'b000);
        push_lvl(t + 23, 3'b001, 3'b000, 3'b000, 3'b001);
        step(8);
        frame(3'b001);
        kif.key_n[0] = 1'b1;
        t = cyc;
        push_pulse(t + 6, 3'b000, 3'b001);
        push_lvl(t + 6, 3'b000, 3'b000, 3'b001, 3'b000);
        step(10);

        // Reset mid-debounce on key 1 while key 2 is held: both restart from scratch
        t = cyc;
        kif.key_n[2] = 1'b0;
        push_pulse(t + 6, 3'b100, 3'b000);
        push_lvl(t + 7, 3'b100, 3'b000, 3'b000, 3'b100);
        step(8);
        kif.key_n[1] = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        t = cyc;
        push_lvl(t + 1, 3'b000, 3'b000, 3'b000, 3'b000);
        push_lvl(t + 5, 3'b000, 3'b000, 3'b000, 3'b000);
        push_pulse(t + 6, 3'b110, 3'b000);
        push_lvl(t + 6, 3'b110, 3'b110, 3'b000, 3'b000);
        push_lvl(t + 7, 3'b110, 3'b000, 3'b000, 3'b110);
        step(10);

        // Anything still queued was never observed
        while (pq.size() != 0) begin
            pe = pq.pop_front();
            chk_cnt++;
            $display("FAIL pulse_missing got none, required cyc=%0d pp=%b rp=%b", pe.cyc, pe.pp, pe.rp);
        end
        while (lq.size() != 0) begin
            chk_cnt++;
            $display("FAIL level_missing got none, required check at cyc=%0d", lq[0].cyc);
            lq.delete(0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Sits directly upstream of platformer_display, between the raw active-low push-buttons (KEY[2:0]) and the game's control input.
- Runs on the 25 MHz pixel clock. Per key it provides:
  - 2-FF synchronisation;
  - counter-based debounce;
  - a clean active-high held level;
  - one-cycle press/release pulses;
  - a sticky per-frame press event, held until the game logic acknowledges it at the frame tick.
- The purpose is that a jump press is never lost or double-counted between frame updates.

Parameters:
- N_KEYS, 3, number of button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable synced cycles needed to accept a change (10 ms at 25 MHz); legal range is 2 or more.
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  N_KEYS  raw buttons, active-low, asynchronous to clk.
- frame_tick  in  1  one-cycle pulse at the start of the vertical blank; acknowledges press_evt.
- held  out  N_KEYS  debounced level, 1 = pressed.
- press_pulse  out  N_KEYS  one-cycle pulse on an accepted press.
- release_pulse  out  N_KEYS  one-cycle pulse on an accepted release.
- press_evt  out  N_KEYS  sticky press flag, cleared by frame_tick.

Behaviour:
- Reset, asynchronous on rst_n low:
  - sync flops are set to 1 (released);
  - counters are 0;
  - held, press_pulse, release_pulse and press_evt are all 0.
- Outputs are glitch-free while rst_n is low.
- Reset asserted mid-debounce discards the partial count. After reset release, no pulse fires for a key that is already held until it has been stable for DEBOUNCE_CYCLES.
- Synchroniser: 2 flops per key. pressed_s = ~sync2.
- Debounce, per channel, all registered:
  - If pressed_s == held, the counter is cleared to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 on that edge, held <= pressed_s and the counter is cleared to 0.
  - Any cycle of agreement in between restarts the count, so a bounce resets the counter.
  - The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- Latency:
  - A raw edge that is stable from cycle 0 changes held at edge 2+DEBOUNCE_CYCLES (2 sync flops plus DEBOUNCE_CYCLES counted cycles).
  - Release uses the identical path and latency.
- Pulses:
  - press_pulse[i] is registered and high for exactly the one cycle in which held[i] first reads 1.
  - release_pulse[i] is high for exactly the one cycle in which held[i] first reads 0.
  - Press and release pulses are never high together for the same key.
- press_evt[i], sticky:
  - Set on press_pulse[i].
  - Cleared on frame_tick.
  - If press_pulse[i] and frame_tick occur in the same cycle, press_evt[i] stays 1. The new press belongs to the next frame and is never dropped.
  - Multiple presses within one frame collapse to a single event.
  - Release does not clear press_evt.
- frame_tick held high for several cycles clears press_evt on every cycle in which no press_pulse occurs.
- Channels are fully independent. Simultaneous changes on several keys are handled in parallel with identical latency.

Decomposition:
- platformer_pkg holds:
  - N_KEYS;
  - key index constants KEY_RIGHT=0, KEY_LEFT=1, KEY_JUMP=2;
  - DEBOUNCE_CYCLES_25MHZ=250000;
  - a DEBOUNCE_CYCLES_SIM=4 override for benches.
- One sub-module, debounce_channel, implements sync, counter, held, the pulses and press_evt for one key. key_conditioner generates N_KEYS instances and fans out frame_tick.

Test Plan (all with DEBOUNCE_CYCLES=4):
- Reset state: hold rst_n=0 with key_n=3'b000. Required: all outputs 0. Release reset and keep the keys low. Required: held=3'b111 exactly 6 cycles after reset release, with press_pulse=3'b111 for that single cycle.
- Clean press/release on key 0: drive key_n[0] low at cycle 0. Required: held[0]=1 and press_pulse[0]=1 at cycle 6; press_pulse[0]=0 at cycle 7. Drive it high at cycle 20. Required: held[0]=0 and release_pulse[0]=1 at cycle 26.
- Bounce rejection: on key 2, toggle key_n low 3 cycles, high 1, low 3, high 1, then low steady. Required: held[2] stays 0 throughout the bouncing and rises exactly 6 cycles after the final steady low, with exactly one press_pulse.
- Sticky event with collision: assert frame_tick in the same cycle as press_pulse[1]. Required: press_evt[1]=1 after that edge. The next frame_tick clears it to 0.
- Event collapse: generate two accepted presses on key 0 within one frame. Required: press_evt[0]=1 and a single clear on frame_tick; press_pulse[0] counted twice.
- Reset mid-debounce: key_n[1] low for 3 cycles (after sync), then pulse rst_n low for 1 cycle. Required: held[1]=0 and no pulse; held[1] rises 6 cycles after rst_n returns high.
